// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit with interrupts.
package mc_pkg;

  typedef enum logic [2:0] {LOAD, ADD, SUB, AND, INC, NEG, XOR, COMP} alu_op_t;

  typedef enum logic [3:0] {
    RESET_S, FETCH, DECODE, R_EXEC, R_WB, MEM_ADDR, LW_READ, LW_WB,
    SW_WRITE, BEQ, JMP, CHECK, EXC_SAVE, EXC_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [2:0] SRCB_B      = 3'd0;
  localparam logic [2:0] SRCB_FOUR   = 3'd1;
  localparam logic [2:0] SRCB_IMM    = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH = 3'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  localparam logic [1:0] CAUSE_IRQ = 2'd0;
  localparam logic [1:0] CAUSE_INV = 2'd1;
  localparam logic [1:0] CAUSE_OVF = 2'd2;

  function automatic logic is_rfunct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_XOR);
  endfunction

  function automatic alu_op_t funct_op(input logic [5:0] f);
    case (f)
      FN_SUB:  return SUB;
      FN_AND:  return AND;
      FN_XOR:  return XOR;
      default: return ADD;
    endcase
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Sticky pending register for the interrupt lines with mask, lowest-index
// priority select and one-hot acknowledge of the line latched at the boundary.
module irq_arbiter #(
  parameter int N_IRQ = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             take,
  input  logic             ack_en,
  output logic             pending,
  output logic [1:0]       sel_idx,
  output logic [N_IRQ-1:0] irq_ack
);

  logic [N_IRQ-1:0] pend_q, pend_d, eff;
  logic [2:0]       sel, svc_q, svc_d;

  assign eff     = pend_q & irq_mask;
  assign pending = |eff;
  assign sel_idx = sel[1:0];

  // Scan from the top so the lowest active index is the last one written.
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eff[i]) sel = 3'(i);
    end
  end

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_ack
    assign irq_ack[gi] = ack_en && (svc_q == 3'(gi));
  end

  // A line still requesting in its ack cycle stays pending.
  always_comb begin
    pend_d = (pend_q & ~irq_ack) | irq;
    svc_d  = take ? sel : svc_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      svc_q  <= '0;
    end else begin
      pend_q <= pend_d;
      svc_q  <= svc_d;
    end
  end

endmodule

// File: rtl/mc_ctrl_irq.sv
// Multicycle MIPS-subset control unit with memory wait states, masked
// external interrupts taken at instruction boundaries, and precise exceptions.
module mc_ctrl_irq
  import mc_pkg::*;
#(
  parameter int N_IRQ    = 4,
  parameter int MEM_WAIT = 1,
  parameter int STATE_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               overflow,
  input  logic [N_IRQ-1:0]   irq,
  input  logic [N_IRQ-1:0]   irq_mask,
  output logic               PCWrite,
  output logic               IorD,
  output logic               wr,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               AWrite,
  output logic               BWrite,
  output logic               AOWR,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic [2:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               EPCWrite,
  output logic               CauseWrite,
  output logic [3:0]         cause,
  output logic [N_IRQ-1:0]   irq_ack,
  output logic [STATE_W-1:0] Estado
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cause_q, cause_d;
  logic          wait_last, take, ack_en, pending, irq_cause;
  logic [1:0]    sel_idx;

  irq_arbiter #(.N_IRQ(N_IRQ)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .irq      (irq),
    .irq_mask (irq_mask),
    .take     (take),
    .ack_en   (ack_en),
    .pending  (pending),
    .sel_idx  (sel_idx),
    .irq_ack  (irq_ack)
  );

  assign wait_last = (cnt_q == CW'(MEM_WAIT - 1));
  assign irq_cause = (cause_q[3:2] == CAUSE_IRQ);
  assign Estado    = STATE_W'(state_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    take       = 1'b0;
    ack_en     = 1'b0;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    wr         = 1'b0;
    IRWrite    = 1'b0;
    ALUSrcA    = 1'b0;
    AWrite     = 1'b0;
    BWrite     = 1'b0;
    AOWR       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcB    = SRCB_B;
    ALUOp      = LOAD;
    PCSource   = PCSRC_ALU;
    EPCWrite   = 1'b0;
    CauseWrite = 1'b0;
    cause      = '0;
    case (state_q)
      RESET_S: state_d = FETCH;
      FETCH: begin
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ADD;
        if (wait_last) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          cnt_d   = '0;
          state_d = DECODE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DECODE: begin
        AWrite  = 1'b1;
        BWrite  = 1'b1;
        AOWR    = 1'b1;
        ALUSrcB = SRCB_IMM_SH;
        ALUOp   = ADD;
        if (opcode == OP_RTYPE && is_rfunct(funct)) state_d = R_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = MEM_ADDR;
        else if (opcode == OP_BEQ)                   state_d = BEQ;
        else if (opcode == OP_J)                     state_d = JMP;
        else begin
          cause_d = {CAUSE_INV, 2'd0};
          state_d = EXC_SAVE;
        end
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        AOWR    = 1'b1;
        ALUOp   = funct_op(funct);
        if (overflow && (funct == FN_ADD || funct == FN_SUB)) begin
          cause_d = {CAUSE_OVF, 2'd0};
          state_d = EXC_SAVE;
        end else begin
          state_d = R_WB;
        end
      end
      R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = CHECK;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ADD;
        AOWR    = 1'b1;
        state_d = (opcode == OP_LW) ? LW_READ : SW_WRITE;
      end
      LW_READ: begin
        IorD = 1'b1;
        if (wait_last) begin
          cnt_d   = '0;
          state_d = LW_WB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LW_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = CHECK;
      end
      SW_WRITE: begin
        IorD    = 1'b1;
        wr      = 1'b1;
        state_d = CHECK;
      end
      BEQ: begin
        ALUSrcA  = 1'b1;
        ALUOp    = SUB;
        PCSource = PCSRC_ALUOUT;
        PCWrite  = zero;
        state_d  = CHECK;
      end
      JMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        state_d  = CHECK;
      end
      CHECK: begin
        if (pending) begin
          take    = 1'b1;
          cause_d = {CAUSE_IRQ, sel_idx};
          cause   = cause_d;
          state_d = EXC_SAVE;
        end else begin
          state_d = FETCH;
        end
      end
      EXC_SAVE: begin
        EPCWrite   = 1'b1;
        CauseWrite = 1'b1;
        cause      = cause_q;
        // Interrupts resume at the next instruction; faults re-point at the culprit.
        if (!irq_cause) begin
          ALUSrcB = SRCB_FOUR;
          ALUOp   = SUB;
        end
        state_d = EXC_JUMP;
      end
      EXC_JUMP: begin
        PCSource = PCSRC_EXC;
        PCWrite  = 1'b1;
        cause    = cause_q;
        ack_en   = irq_cause;
        state_d  = FETCH;
      end
      default: state_d = RESET_S;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_S;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule
